// File: rtl/dendy_mapper.sv
// dendy_mapper: runtime-selectable NROM/MMC1/UxROM/CNROM cartridge mapper
// Ports:
//   clock, reset_n        system clock, asynchronous active-low reset
//   ce                    CPU clock enable, one pulse per CPU cycle
//   mapper                0 NROM, 1 MMC1, 2 UxROM, 3 CNROM
//   prga, prgd, prgw      CPU address, write data, write request
//   chra                  PPU address
//   prg_address           PRG-ROM address (PRG_AW bits)
//   chr_address           CHR-ROM address (CHR_AW bits)
//   vram_a10              nametable RAM A10 after mirroring
//   wram_en               $6000-$7FFF PRG-RAM enable
module dendy_mapper #(
    parameter int PRG_AW   = 17,
    parameter int CHR_AW   = 13,
    parameter bit MIRROR_V = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ce,
    input  logic [1:0]        mapper,
    input  logic [15:0]       prga,
    input  logic [7:0]        prgd,
    input  logic              prgw,
    input  logic [13:0]       chra,
    output logic [PRG_AW-1:0] prg_address,
    output logic [CHR_AW-1:0] chr_address,
    output logic              vram_a10,
    output logic              wram_en
);
    logic [4:0]  mmc_ctl, mmc_chr0, mmc_chr1, mmc_prg, shift, ux_bank, sv;
    logic [3:0]  cn_bank;
    logic        last_wev, wev, acc;
    logic [7:0]  bank16;
    logic [21:0] mmc_prg_full, ux_prg_full, prg_full;
    logic [17:0] mmc_chr_full, chr_full;
    assign wev = ce & prgw & prga[15];
    // MMC1 ignores a write whose preceding CPU cycle was also a write
    assign acc = wev & ~last_wev;
    assign sv  = {prgd[0], shift[4:1]};
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            mmc_ctl  <= 5'h0C;
            mmc_chr0 <= '0;
            mmc_chr1 <= '0;
            mmc_prg  <= '0;
            shift    <= 5'b10000;
            ux_bank  <= '0;
            cn_bank  <= '0;
            last_wev <= 1'b0;
        end else begin
            if (ce) last_wev <= wev;
            if (wev) begin
                ux_bank <= prgd[4:0];
                cn_bank <= prgd[3:0];
            end
            if (acc) begin
                if (prgd[7]) begin
                    shift   <= 5'b10000;
                    mmc_ctl <= mmc_ctl | 5'h0C;
                end else if (shift[0]) begin
                    // marker bit reached the bottom: this is the 5th bit
                    shift <= 5'b10000;
                    case (prga[14:13])
                        2'd0:    mmc_ctl  <= sv;
                        2'd1:    mmc_chr0 <= sv;
                        2'd2:    mmc_chr1 <= sv;
                        default: mmc_prg  <= sv;
                    endcase
                end else begin
                    shift <= sv;
                end
            end
        end
    // 16K bank for MMC1 modes 2 (fixed first) and 3 (fixed last)
    assign bank16 = mmc_ctl[2] ? (prga[14] ? 8'hFF : {4'h0, mmc_prg[3:0]})
                               : (prga[14] ? {4'h0, mmc_prg[3:0]} : 8'h00);
    assign mmc_prg_full = mmc_ctl[3] ? {bank16, prga[13:0]} : {4'h0, mmc_prg[3:1], prga[14:0]};
    assign ux_prg_full  = {prga[14] ? 8'hFF : {3'b000, ux_bank}, prga[13:0]};
    assign prg_full     = mapper == 2'd1 ? mmc_prg_full :
                          mapper == 2'd2 ? ux_prg_full  : {7'h00, prga[14:0]};
    assign mmc_chr_full = mmc_ctl[4] ? {1'b0, chra[12] ? mmc_chr1 : mmc_chr0, chra[11:0]}
                                     : {1'b0, mmc_chr0[4:1], chra[12:0]};
    assign chr_full     = mapper == 2'd1 ? mmc_chr_full :
                          mapper == 2'd3 ? {1'b0, cn_bank, chra[12:0]} : {5'h00, chra[12:0]};
    assign prg_address  = prg_full[PRG_AW-1:0];
    assign chr_address  = chr_full[CHR_AW-1:0];
    assign vram_a10     = mapper == 2'd1 ? (mmc_ctl[1] ? (mmc_ctl[0] ? chra[11] : chra[10]) : mmc_ctl[0])
                                         : (MIRROR_V ? chra[10] : chra[11]);
    assign wram_en      = mapper == 2'd1 ? ~mmc_prg[4] : 1'b1;
endmodule
